// File: rtl/id_ex_stage_buffer.sv
// Elastic ID/EX stage: main entry plus one skid entry, valid/ready on both sides.
// State updates on the falling clock edge; async active-low reset.
module id_ex_stage_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc_plus_two,
  input  logic [DATA_W-1:0] in_read_data_1,
  input  logic [DATA_W-1:0] in_read_data_2,
  input  logic [DATA_W-1:0] in_immediate,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_dest,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc_plus_two,
  output logic [DATA_W-1:0] out_read_data_1,
  output logic [DATA_W-1:0] out_read_data_2,
  output logic [DATA_W-1:0] out_immediate,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_dest,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  dest;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_e;
  logic   push, pop;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_e      = '0;
    in_e.pc   = in_pc_plus_two;
    in_e.rd1  = in_read_data_1;
    in_e.rd2  = in_read_data_2;
    in_e.imm  = in_immediate;
    in_e.rt   = in_rt;
    in_e.rd   = in_rd;
    in_e.dest = in_reg_dest ? in_rd : in_rt;
    in_e.ctrl = in_ctrl;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over any handshake in the same cycle
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in)
        main_q <= in_e;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_e;
      // Entries left invalid must never carry live control bits
      if (state_d == EMPTY)
        main_q.ctrl <= '0;
      if (state_d != FULL)
        skid_q.ctrl <= '0;
    end
  end

  assign out_pc_plus_two = main_q.pc;
  assign out_read_data_1 = main_q.rd1;
  assign out_read_data_2 = main_q.rd2;
  assign out_immediate   = main_q.imm;
  assign out_rt          = main_q.rt;
  assign out_rd          = main_q.rd;
  assign out_dest        = main_q.dest;
  assign out_ctrl        = main_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// Directed vector bench for id_ex_stage_buffer.
// Inputs change just after the falling edge; outputs checked 1ns after it.
module tb_id_ex_stage_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc_plus_two, in_read_data_1, in_read_data_2, in_immediate;
  logic [2:0]  in_rt, in_rd;
  logic        in_reg_dest;
  logic [7:0]  in_ctrl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc_plus_two, out_read_data_1, out_read_data_2, out_immediate;
  logic [2:0]  out_rt, out_rd, out_dest;
  logic [7:0]  out_ctrl;

  int checks = 0;
  int errors = 0;

  id_ex_stage_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus_two(in_pc_plus_two), .in_read_data_1(in_read_data_1),
    .in_read_data_2(in_read_data_2), .in_immediate(in_immediate),
    .in_rt(in_rt), .in_rd(in_rd), .in_reg_dest(in_reg_dest),
    .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_plus_two(out_pc_plus_two), .out_read_data_1(out_read_data_1),
    .out_read_data_2(out_read_data_2), .out_immediate(out_immediate),
    .out_rt(out_rt), .out_rd(out_rd), .out_dest(out_dest),
    .out_ctrl(out_ctrl)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] pc;
    logic        rdst;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [7:0]  ctrl;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic        erdy;
    logic [15:0] epc;
    logic [2:0]  edest;
    logic [7:0]  ectrl;
  } vec_t;

  vec_t vec[17];

  function automatic vec_t mk(
    logic iv, logic [15:0] pc, logic rdst, logic [2:0] rt, logic [2:0] rd,
    logic [7:0] ctrl, logic fl, logic ordy, logic ev, logic erdy,
    logic [15:0] epc, logic [2:0] edest, logic [7:0] ectrl);
    vec_t v;
    v.iv = iv; v.pc = pc; v.rdst = rdst; v.rt = rt; v.rd = rd;
    v.ctrl = ctrl; v.fl = fl; v.ordy = ordy; v.ev = ev; v.erdy = erdy;
    v.epc = epc; v.edest = edest; v.ectrl = ectrl;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    in_valid       = v.iv;
    in_pc_plus_two = v.pc;
    in_read_data_1 = v.pc ^ 16'hA5A5;
    in_read_data_2 = {v.pc[7:0], v.pc[15:8]};
    in_immediate   = v.pc + 16'h0100;
    in_reg_dest    = v.rdst;
    in_rt          = v.rt;
    in_rd          = v.rd;
    in_ctrl        = v.ctrl;
    flush          = v.fl;
    out_ready      = v.ordy;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(string tag, logic ev, logic erdy,
                            logic [15:0] epc, logic [2:0] edest,
                            logic [7:0] ectrl);
    chk({tag, "_valid"}, 16'(out_valid), 16'(ev));
    chk({tag, "_ready"}, 16'(in_ready), 16'(erdy));
    chk({tag, "_ctrl"}, 16'(out_ctrl), 16'(ectrl));
    if (ev) begin
      chk({tag, "_pc"}, out_pc_plus_two, epc);
      chk({tag, "_dest"}, 16'(out_dest), 16'(edest));
      chk({tag, "_rd1"}, out_read_data_1, epc ^ 16'hA5A5);
      chk({tag, "_rd2"}, out_read_data_2, {epc[7:0], epc[15:8]});
      chk({tag, "_imm"}, out_immediate, epc + 16'h0100);
    end
  endtask

  initial begin
    // streaming, out_ready=1
    vec[0]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 0, 1, 16'h0000, 0, 8'h00);
    vec[1]  = mk(1, 16'h0002, 1, 2, 5, 8'h81, 0, 1, 1, 1, 16'h0002, 5, 8'h81);
    vec[2]  = mk(1, 16'h0004, 0, 2, 5, 8'h42, 0, 1, 1, 1, 16'h0004, 2, 8'h42);
    vec[3]  = mk(1, 16'h0006, 1, 7, 1, 8'h13, 0, 1, 1, 1, 16'h0006, 1, 8'h13);
    vec[4]  = mk(1, 16'h0008, 0, 6, 3, 8'h24, 0, 1, 1, 1, 16'h0008, 6, 8'h24);
    vec[5]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 0, 1, 16'h0000, 0, 8'h00);
    // back-pressure: A, B fill, extra push refused, then drain
    vec[6]  = mk(1, 16'h0010, 1, 1, 4, 8'h01, 0, 0, 1, 1, 16'h0010, 4, 8'h01);
    vec[7]  = mk(1, 16'h0012, 0, 3, 6, 8'h02, 0, 0, 1, 0, 16'h0010, 4, 8'h01);
    vec[8]  = mk(1, 16'h0014, 1, 0, 0, 8'hF0, 0, 0, 1, 0, 16'h0010, 4, 8'h01);
    vec[9]  = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 1, 1, 16'h0012, 3, 8'h02);
    vec[10] = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 0, 1, 16'h0000, 0, 8'h00);
    // flush from FULL, then flush with push&pop from ONE
    vec[11] = mk(1, 16'h0020, 1, 0, 7, 8'h81, 0, 0, 1, 1, 16'h0020, 7, 8'h81);
    vec[12] = mk(1, 16'h0022, 0, 5, 2, 8'h18, 0, 0, 1, 0, 16'h0020, 7, 8'h81);
    vec[13] = mk(1, 16'h0024, 1, 1, 1, 8'hFF, 1, 1, 0, 1, 16'h0000, 0, 8'h00);
    vec[14] = mk(1, 16'h0026, 1, 1, 2, 8'h3C, 0, 0, 1, 1, 16'h0026, 2, 8'h3C);
    vec[15] = mk(1, 16'h0028, 0, 4, 6, 8'hFF, 1, 1, 0, 1, 16'h0000, 0, 8'h00);
    vec[16] = mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 0, 1, 16'h0000, 0, 8'h00);

    // reset held with a live input presented
    rst_n = 1'b0;
    drive(mk(1, 16'h00FE, 1, 1, 4, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_ready", 16'(in_ready), 16'h1);
    chk("rst_ctrl", 16'(out_ctrl), 16'h0);
    chk("rst_pc", out_pc_plus_two, 16'h0);
    rst_n = 1'b1;
    step();
    expect_out("rel", 1, 1, 16'h00FE, 3'd4, 8'hFF);

    for (int i = 0; i < 17; i++) begin
      drive(vec[i]);
      step();
      expect_out($sformatf("v%0d", i), vec[i].ev, vec[i].erdy,
                 vec[i].epc, vec[i].edest, vec[i].ectrl);
    end

    // async reset between edges while FULL
    drive(mk(1, 16'h0030, 1, 2, 5, 8'hC3, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 16'h0032, 0, 2, 5, 8'h5A, 0, 0, 0, 0, 0, 0, 0));
    step();
    expect_out("full", 1, 0, 16'h0030, 3'd5, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(out_valid), 16'h0);
    chk("arst_ready", 16'(in_ready), 16'h1);
    chk("arst_ctrl", 16'(out_ctrl), 16'h0);
    chk("arst_pc", out_pc_plus_two, 16'h0);
    chk("arst_dest", 16'(out_dest), 16'h0);
    rst_n = 1'b1;
    drive(mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    step();
    expect_out("post", 0, 1, 16'h0000, 3'd0, 8'h00);
    drive(mk(1, 16'h0034, 1, 3, 6, 8'h11, 0, 1, 0, 0, 0, 0, 0));
    step();
    expect_out("resume", 1, 1, 16'h0034, 3'd6, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
